// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared types for the RAM responder. The PU index type is
//               sized for up to c_PU_COUNT_MAX requesters, so one tag format
//               serves every PU_COUNT setting of the responder.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    localparam int c_PU_COUNT_MAX = 256;

    // Index width for a given PU count. A single PU still needs one bit.
    function automatic int f_pu_idx_w(input int pu_count);
        return (pu_count > 1) ? $clog2(pu_count) : 1;
    endfunction

    localparam int c_PU_IDX_W = f_pu_idx_w(c_PU_COUNT_MAX);

    typedef logic [c_PU_IDX_W-1:0] pu_idx_t;

    // One stage of the read-return tag pipeline.
    typedef struct packed {
        logic    vld;
        pu_idx_t idx;
    } ret_tag_t;

endpackage
`default_nettype wire

// File: rtl/ex_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ex_rr_arbiter
// Description : Round-robin arbiter. The search starts at the pointer and runs
//               upwards, wrapping from PU_COUNT-1 to 0; the first requester
//               wins. After a grant to i the pointer moves to (i+1) mod
//               PU_COUNT, otherwise it holds.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_req         - per-PU request
//               o_gnt         - one-hot grant (combinational, 0 in reset)
//               o_gnt_vld     - any grant this cycle
//               o_gnt_idx     - index of the granted PU
// Revision    : 1.0 - initial release
// ============================================================================
module ex_rr_arbiter
    import ex_pkg::*;
#(
    parameter int PU_COUNT = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PU_COUNT-1:0] i_req,
    output logic [PU_COUNT-1:0] o_gnt,
    output logic                o_gnt_vld,
    output pu_idx_t             o_gnt_idx
);

    pu_idx_t r_ptr;
    logic    w_found;
    pu_idx_t w_win;
    int      w_ptr;
    int      w_dist;
    int      w_best;

    // Winner is the requester with the smallest forward distance from r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_ptr   = int'(r_ptr);
        w_dist  = 0;
        w_best  = PU_COUNT;
        for (int i = 0; i < PU_COUNT; i++) begin
            w_dist = (i >= w_ptr) ? (i - w_ptr) : (i + PU_COUNT - w_ptr);
            if (i_req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_win   = pu_idx_t'(i);
                w_found = 1'b1;
            end
        end
        if (rst) begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < PU_COUNT; i++) begin
            o_gnt[i] = w_found && (int'(w_win) == i);
        end
    end

    assign o_gnt_vld = w_found;
    assign o_gnt_idx = w_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (int'(w_win) == PU_COUNT - 1) ? '0 : w_win + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ex_ram_responder
// Description : RAM-side responder for the per-PU access bus. Arbitrates PU
//               requests round-robin onto one single-port RAM, registers the
//               RAM command, and returns read data to the requesting PU.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               req        - per-PU request, held until granted
//               wr_n_rd    - per-PU 1=write, 0=read
//               wr_data    - flattened per-PU write data
//               addr       - flattened per-PU address
//               gnt        - one-hot accept (combinational)
//               rd_valid   - one-hot read-return strobe
//               rd_data    - read data, qualified by rd_valid
//               ram_en/ram_we/ram_addr/ram_wdata - registered RAM command
//               ram_rdata  - RAM read data, RAM_RD_LATENCY after ram_en
// Revision    : 1.0 - initial release
// ============================================================================
module ex_ram_responder
    import ex_pkg::*;
#(
    parameter int RAM_WIDTH      = 16,
    parameter int PU_COUNT       = 7,
    parameter int ADDR_WIDTH     = 10,
    parameter int RAM_RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PU_COUNT-1:0]            req,
    input  logic [PU_COUNT-1:0]            wr_n_rd,
    input  logic [PU_COUNT*RAM_WIDTH-1:0]  wr_data,
    input  logic [PU_COUNT*ADDR_WIDTH-1:0] addr,
    output logic [PU_COUNT-1:0]            gnt,
    output logic [PU_COUNT-1:0]            rd_valid,
    output logic [RAM_WIDTH-1:0]           rd_data,
    output logic                           ram_en,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [RAM_WIDTH-1:0]           ram_wdata,
    input  logic [RAM_WIDTH-1:0]           ram_rdata
);

    logic                  w_gnt_vld;
    pu_idx_t               w_gnt_idx;

    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [RAM_WIDTH-1:0]  w_sel_wdata;

    logic                  r_ram_en;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [RAM_WIDTH-1:0]  r_ram_wdata;
    pu_idx_t               r_ram_idx;

    ret_tag_t              r_tag [RAM_RD_LATENCY];
    ret_tag_t              w_tag_in;
    ret_tag_t              w_tag_out;
    logic                  w_ret_vld;
    logic [RAM_WIDTH-1:0]  r_rd_data_hold;

    ex_rr_arbiter #(
        .PU_COUNT (PU_COUNT)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req),
        .o_gnt     (gnt),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
    );

    // Pick the granted PU's slot out of the flattened buses.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < PU_COUNT; i++) begin
            if (int'(w_gnt_idx) == i) begin
                w_sel_we    = wr_n_rd[i];
                w_sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = wr_data[i*RAM_WIDTH +: RAM_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_idx   <= '0;
        end else begin
            r_ram_en <= w_gnt_vld;
            r_ram_we <= w_gnt_vld && w_sel_we;
            if (w_gnt_vld) begin
                r_ram_addr  <= w_sel_addr;
                // Reads drive zero so the RAM bus never carries stale PU data.
                r_ram_wdata <= w_sel_we ? w_sel_wdata : '0;
                r_ram_idx   <= w_gnt_idx;
            end
        end
    end

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

    // Tag enters when the read is on the RAM bus and leaves in the cycle
    // the RAM presents its data, so the pipeline is exactly latency deep.
    assign w_tag_in = '{vld: r_ram_en && !r_ram_we, idx: r_ram_idx};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RAM_RD_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int s = 1; s < RAM_RD_LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_tag_out = r_tag[RAM_RD_LATENCY-1];
    assign w_ret_vld = !rst && w_tag_out.vld;

    always_comb begin
        rd_valid = '0;
        for (int i = 0; i < PU_COUNT; i++) begin
            rd_valid[i] = w_ret_vld && (int'(w_tag_out.idx) == i);
        end
    end

    // rd_data passes ram_rdata straight through on a return and otherwise
    // holds the last returned word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data_hold <= '0;
        end else if (w_ret_vld) begin
            r_rd_data_hold <= ram_rdata;
        end
    end

    assign rd_data = w_ret_vld ? ram_rdata : r_rd_data_hold;

endmodule
`default_nettype wire
